serial_word_assembler: RTL and testbench

Downstream consumer of the nibble shift-register stage. Takes the serial bit stream it emits, hunts for a sync pattern, and assembles the following WIDTH bits (LSB first) into a parallel word. Completed words are presented through a 2-entry output buffer with a valid/ready handshake. Overflow is reported by a sticky flag, and accepted words are counted.

---
 rtl/serial_word_assembler_if.sv | 35 +++
 rtl/serial_word_assembler.sv | 151 +++++++++++++++
 tb/tb_serial_word_assembler.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_assembler_if.sv
// ---------------------------------------------------------------------------
// serial_word_assembler_if
//   Serial-in / word-out bundle for serial_word_assembler.
//   din, din_en  : qualified serial bit stream (producer -> assembler)
//   dout         : head word of the assembler's output buffer
//   dout_valid   : output buffer non-empty
//   dout_ready   : consumer accepts the head word when dout_valid=1
//   master modport: the side that supplies bits and consumes words
//   slave  modport: the assembler itself
// ---------------------------------------------------------------------------
interface serial_word_assembler_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             din_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output din,
        output din_en,
        output dout_ready,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  din,
        input  din_en,
        input  dout_ready,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/serial_word_assembler.sv
// ---------------------------------------------------------------------------
// serial_word_assembler
//   Hunts the qualified serial stream for a 4-bit sync pattern, then collects
//   the next WIDTH bits LSB first into a word and pushes it into a 2-entry
//   output FIFO with a valid/ready handshake.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : din/din_en in, dout/dout_valid out, dout_ready in (slave)
//   clear     : synchronous clear of overflow and frame_cnt
//   overflow  : sticky, a completed word was dropped because the FIFO was full
//   frame_cnt : words written into the FIFO, modulo 256
//   busy      : assembler is collecting data bits
// ---------------------------------------------------------------------------
module serial_word_assembler #(
    parameter int         WIDTH = 8,
    parameter logic [3:0] SYNC  = 4'b1011
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_word_assembler_if.slave  bus,
    input  logic                    clear,
    output logic                    overflow,
    output logic [7:0]              frame_cnt,
    output logic                    busy
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {HUNT, DATA} state_t;

    state_t           state, state_next;
    logic [3:0]       hist, hist_shift;
    logic [2:0]       hist_cnt;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] word, push_word;
    logic             word_done;

    logic [WIDTH-1:0] head, tail;
    logic [1:0]       count;
    logic             pop, push_ok, drop;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next             = state;
        hist_shift             = {bus.din, hist[3:1]};
        word_done              = 1'b0;
        push_word              = word;
        push_word[WIDTH-1]     = bus.din;   // last bit bypasses the word register
        if (bus.din_en) begin
            unique case (state)
                HUNT: if (hist_shift == SYNC && hist_cnt >= 3'd3) state_next = DATA;
                DATA: if (bit_cnt == LAST) begin
                    word_done  = 1'b1;
                    state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign busy = (state == DATA);

    // ---------------- sync history and word assembly ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            hist_cnt <= '0;
            bit_cnt  <= '0;
            word     <= '0;
        end else if (bus.din_en) begin
            if (state == HUNT) begin
                hist <= hist_shift;
                if (hist_cnt != 3'd4) hist_cnt <= hist_cnt + 3'd1;
                bit_cnt <= '0;
            end else begin
                word[bit_cnt] <= bus.din;
                bit_cnt       <= bit_cnt + 1'b1;
                // Re-entering HUNT must see a fresh history, so a pattern
                // straddling the end of a word cannot cause a lock.
                if (word_done) begin
                    hist     <= '0;
                    hist_cnt <= '0;
                end
            end
        end
    end

    // ---------------- 2-entry output FIFO ----------------
    assign pop     = bus.dout_valid & bus.dout_ready;
    assign push_ok = word_done & ((count != 2'd2) | pop);
    assign drop    = word_done & ~push_ok;

    // head is the registered dout; tail holds the second word when full.
    // NOTE: the storage registers are reset because dout must read 0 after
    // reset; a FIFO whose contents are never observed empty could skip it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case (count)
                2'd0: if (push_ok) begin
                    head  <= push_word;
                    count <= 2'd1;
                end
                2'd1: begin
                    if (pop && push_ok)  head <= push_word;
                    else if (push_ok) begin
                        tail  <= push_word;
                        count <= 2'd2;
                    end else if (pop)    count <= 2'd0;
                end
                2'd2: if (pop) begin
                    head <= tail;
                    if (push_ok) tail  <= push_word;
                    else         count <= 2'd1;
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign bus.dout       = head;
    assign bus.dout_valid = (count != 2'd0);

    // ---------------- status ----------------
    // A same-edge event beats clear: drop leaves overflow set, a push leaves
    // frame_cnt at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (drop)       overflow <= 1'b1;
            else if (clear) overflow <= 1'b0;

            if (push_ok)    frame_cnt <= clear ? 8'd1 : frame_cnt + 8'd1;
            else if (clear) frame_cnt <= 8'd0;
        end
    end
endmodule

// File: tb/tb_serial_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_serial_word_assembler
//   Self-checking bench for serial_word_assembler. Expected words are queued
//   when a frame is sent; a monitor pops and compares them whenever the DUT
//   hands a word over (dout_valid & dout_ready).
// ---------------------------------------------------------------------------
module tb_serial_word_assembler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       overflow;
    logic [7:0] frame_cnt;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         exp_fc = 0;
    logic [3:0] sync_seq = 4'b1011;   // transmitted bit 0 first: 1,1,0,1

    serial_word_assembler_if #(.WIDTH(8)) bus ();

    serial_word_assembler #(.WIDTH(8), .SYNC(4'b1011)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear     (clear),
        .overflow  (overflow),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: inputs change at posedge+1, so negedge sees the
    // values the DUT will sample on the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.dout_valid && bus.dout_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: dout=%h, no word expected", bus.dout);
            end else begin
                logic [7:0] w;
                w = exp_q.pop_front();
                if (bus.dout !== w) begin
                    errors++;
                    $display("FAIL scoreboard_word: dout=%h expected=%h", bus.dout, w);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [7:0] w);
        exp_q.push_back(w);
        exp_fc = (exp_fc + 1) % 256;
    endtask

    task automatic send_bit(input logic b);
        bus.din    = b;
        bus.din_en = 1'b1;
        cycle();
        bus.din_en = 1'b0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 4; i++) send_bit(sync_seq[i]);
    endtask

    // Full frame; optionally an idle din_en=0 cycle (random din) after each bit.
    task automatic send_frame(input logic [7:0] w, input bit toggle,
                              output int busy_n, output int first_valid);
        logic [11:0] bits;
        int          ncyc;
        bits        = {w, sync_seq};
        busy_n      = 0;
        first_valid = 0;
        ncyc        = 0;
        for (int i = 0; i < 12; i++) begin
            send_bit(bits[i]);
            ncyc++;
            if (busy) busy_n++;
            if (bus.dout_valid && first_valid == 0) first_valid = ncyc;
            if (toggle) begin
                bus.din = 1'($urandom);
                cycle();
                ncyc++;
                if (busy) busy_n++;
                if (bus.dout_valid && first_valid == 0) first_valid = ncyc;
            end
        end
    endtask

    task automatic send_plain(input logic [7:0] w);
        int b, f;
        send_frame(w, 1'b0, b, f);
    endtask

    task automatic check_outputs(input string name, input logic [7:0] e_dout,
                                 input logic e_valid, input logic e_ovf,
                                 input logic [7:0] e_fc, input logic e_busy);
        checks += 5;
        if (bus.dout !== e_dout) begin errors++; $display("FAIL %s_dout: got %h expected %h", name, bus.dout, e_dout); end
        if (bus.dout_valid !== e_valid) begin errors++; $display("FAIL %s_valid: got %b expected %b", name, bus.dout_valid, e_valid); end
        if (overflow !== e_ovf) begin errors++; $display("FAIL %s_overflow: got %b expected %b", name, overflow, e_ovf); end
        if (frame_cnt !== e_fc) begin errors++; $display("FAIL %s_frame_cnt: got %0d expected %0d", name, frame_cnt, e_fc); end
        if (busy !== e_busy) begin errors++; $display("FAIL %s_busy: got %b expected %b", name, busy, e_busy); end
    endtask

    task automatic drain();
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        cycle();
        checks++;
        if (exp_q.size() != 0 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: pending=%0d valid=%b expected pending=0 valid=0", exp_q.size(), bus.dout_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        check_outputs("reset_held", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        cycle();
        rst = 1'b0;
        cycle();
        check_outputs("reset_released", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_basic();
        int busy_n, first_valid, valid_n;
        bus.dout_ready = 1'b1;
        push_expect(8'hA5);
        send_frame(8'hA5, 1'b0, busy_n, first_valid);
        check_outputs("basic_done", 8'hA5, 1'b1, 1'b0, exp_fc[7:0], 1'b0);
        valid_n = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (bus.dout_valid) valid_n++;
        end
        checks += 3;
        if (busy_n != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", busy_n); end
        if (valid_n != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_n); end
        if (first_valid != 12) begin errors++; $display("FAIL basic_latency: got %0d expected 12", first_valid); end
    endtask

    task automatic test_din_en_gaps();
        int busy_n, first_valid;
        push_expect(8'hA5);
        send_frame(8'hA5, 1'b1, busy_n, first_valid);
        checks += 2;
        if (first_valid != 23) begin errors++; $display("FAIL gap_latency: got %0d expected 23", first_valid); end
        if (frame_cnt !== exp_fc[7:0]) begin errors++; $display("FAIL gap_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_no_false_sync();
        logic [6:0] pre;
        int         locks;
        rst = 1'b1; #1; rst = 1'b0;
        exp_q.delete();
        exp_fc = 0;
        cycle();
        pre   = 7'b1011101;   // sent LSB first: 1,0,1,1,1,0,1 -> sync only at the end
        locks = 0;
        for (int i = 0; i < 6; i++) begin
            send_bit(pre[i]);
            if (busy) locks++;
        end
        send_bit(pre[6]);
        checks += 2;
        if (locks != 0) begin errors++; $display("FAIL prefix_false_lock: got %0d locks expected 0", locks); end
        if (busy !== 1'b1) begin errors++; $display("FAIL prefix_lock: got busy=%b expected 1", busy); end
        // data 0x0B carries 1,1,0,1 in its first four bits: must not relock
        push_expect(8'h0B);
        locks = 0;
        for (int i = 0; i < 7; i++) begin
            logic [7:0] w;
            w = 8'h0B;
            send_bit(w[i]);
            if (busy) locks++;
        end
        send_bit(1'b0);
        check_outputs("embedded_sync", 8'h0B, 1'b1, 1'b0, exp_fc[7:0], 1'b0);
        checks++;
        if (locks != 7) begin errors++; $display("FAIL embedded_busy: got %0d expected 7", locks); end
        cycle();
    endtask

    task automatic test_overflow();
        bus.dout_ready = 1'b0;
        push_expect(8'h11);
        push_expect(8'h22);
        send_plain(8'h11);
        send_plain(8'h22);
        send_plain(8'h33);
        cycle();
        check_outputs("overflow_full", 8'h11, 1'b1, 1'b1, exp_fc[7:0], 1'b0);
        drain();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        exp_fc = 0;
        check_outputs("clear", 8'h22, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_full_pop_push();
        logic [7:0] w;
        bus.dout_ready = 1'b0;
        push_expect(8'h44);
        push_expect(8'h55);
        push_expect(8'h66);
        send_plain(8'h44);
        send_plain(8'h55);
        send_sync();
        w = 8'h66;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        bus.dout_ready = 1'b1;
        send_bit(w[7]);
        bus.dout_ready = 1'b0;
        check_outputs("pop_push", 8'h55, 1'b1, 1'b0, exp_fc[7:0], 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        bus.dout_ready = 1'b0;
        push_expect(8'h5A);
        send_plain(8'h5A);
        send_sync();
        w = 8'hC3;
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        rst = 1'b1;
        #1;
        check_outputs("reset_mid_word", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        exp_q.delete();
        exp_fc = 0;
        cycle();
        rst = 1'b0;
        bus.dout_ready = 1'b1;
        push_expect(8'hC3);
        send_plain(8'hC3);
        cycle();
        checks++;
        if (frame_cnt !== exp_fc[7:0]) begin errors++; $display("FAIL after_reset_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_wrap_and_clear();
        logic [7:0] w;
        bus.dout_ready = 1'b1;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        exp_fc = 0;
        for (int i = 0; i < 255; i++) begin
            w = 8'($urandom);
            push_expect(w);
            send_plain(w);
        end
        checks++;
        if (frame_cnt !== 8'd255) begin errors++; $display("FAIL frame_cnt_255: got %0d expected 255", frame_cnt); end
        push_expect(8'h3C);
        send_plain(8'h3C);
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL frame_cnt_wrap: got %0d expected 0", frame_cnt); end
        w = 8'h96;
        push_expect(w);
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        clear = 1'b1;
        send_bit(w[7]);
        clear = 1'b0;
        exp_fc = 1;
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL clear_with_push: got %0d expected 1", frame_cnt); end
        drain();
    endtask

    initial begin
        bus.din        = 1'b0;
        bus.din_en     = 1'b0;
        bus.dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_din_en_gaps();
        test_no_false_sync();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_word();
        test_wrap_and_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a task ever stalls; reports before ending.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors + 1);
        $fatal(1, "timeout");
    end
endmodule
